// File: rtl/encoder_stream.sv
// encoder_stream: 4-to-2 priority encoder with a valid/ready handshake on both sides.
// Each accepted word is encoded as {err, index} and queued in a 2-entry FIFO.
// err_cnt counts accepted words that were not exactly one-hot, saturating at 255.
module encoder_stream #(
  parameter int PRIORITY_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_a,
  output logic       out_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [7:0] err_cnt_reg;
  logic [2:0] fifo_mem [2];

  logic       accept;
  logic       pop;
  logic [1:0] enc_idx;
  logic       enc_err;
  logic [2:0] head;

  // Encode the offered word. The scan order decides which set bit wins on multi-hot:
  // an ascending scan leaves the highest set bit, a descending scan the lowest.
  always_comb begin
    enc_idx = 2'b00;
    if (PRIORITY_HIGH != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (in_y[i]) enc_idx = i[1:0];
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (in_y[i]) enc_idx = i[1:0];
      end
    end
    // Not one-hot: either no bit set, or clearing the lowest set bit leaves another.
    enc_err = (in_y == 4'b0000) || ((in_y & (in_y - 4'd1)) != 4'b0000);
  end

  // Handshake qualifiers. in_ready uses rst_n so nothing is taken while reset is held.
  always_comb begin
    in_ready  = (state_reg != FULL) && rst_n;
    out_valid = (state_reg != EMPTY);
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Next occupancy from the accept/pop combination; unlisted combinations hold.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !pop)      state_next = FULL;
        else if (pop && !accept) state_next = EMPTY;
      end
      FULL:  if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Occupancy, pointers and the error counter; reset discards any buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= EMPTY;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      err_cnt_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      if (accept) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)    rd_ptr_reg <= ~rd_ptr_reg;
      if (accept && enc_err && (err_cnt_reg != 8'hFF)) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  // FIFO storage needs no reset: entries are only visible while out_valid is high.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr_reg] <= {enc_err, enc_idx};
  end

  // Present the head entry, forced to zero while the FIFO is empty.
  always_comb begin
    head    = fifo_mem[rd_ptr_reg];
    out_a   = out_valid ? head[1:0] : 2'b00;
    out_err = out_valid ? head[2]   : 1'b0;
    err_cnt = err_cnt_reg;
  end

endmodule

// File: doc/encoder_stream.md
ENCODER_STREAM -- requirements
Module: encoder_stream

Interface
REQ-001 The block SHALL have one parameter: PRIORITY_HIGH, default 1, selects the highest set bit (1) or the lowest set bit (0) when the input word is multi-hot.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  in_y holds a word to be encoded.
REQ-005 in_ready  output  1  the block can accept a word this cycle.
REQ-006 in_y  input  4  input word, nominally one-hot, in the same format as the 2-to-4 decoder output.
REQ-007 out_valid  output  1  out_a and out_err hold an encoded result.
REQ-008 out_ready  input  1  the downstream stage takes the result this cycle.
REQ-009 out_a  output  2  encoded index.
REQ-010 out_err  output  1  the word behind this result was not exactly one-hot.
REQ-011 err_cnt  output  8  count of accepted non-one-hot words.

Function
REQ-012 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-013 Pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-014 Encoding SHALL be the inverse of the decoder: 0001->00, 0010->01, 0100->10, 1000->11, with out_err=0.
REQ-015 in_y=0000 SHALL encode as out_a=00 with out_err=1.
REQ-016 Multi-hot in_y SHALL encode the index of the highest set bit when PRIORITY_HIGH=1, else the lowest set bit, with out_err=1.
REQ-017 Results SHALL be stored in a 2-entry FIFO of {out_err, out_a}, read in acceptance order.
REQ-018 FIFO occupancy states SHALL be EMPTY (0 entries), ONE (1 entry) and FULL (2 entries).
REQ-019 State transitions SHALL follow the accept/pop combination:
- EMPTY + accept -> ONE
- ONE + accept, no pop -> FULL
- ONE + pop, no accept -> EMPTY
- ONE + accept and pop -> ONE (the new entry replaces the popped one)
- FULL + pop -> ONE
- all other combinations -> no change
REQ-020 in_ready SHALL be 1 exactly when the state is not FULL and rst_n=1; it SHALL depend on state only, never combinationally on out_ready.
REQ-021 out_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-022 Latency: a word accepted at edge N into an EMPTY FIFO SHALL show out_valid=1 and its result from just after edge N (one cycle).
REQ-023 While out_valid=1 and out_ready=0, out_a and out_err SHALL hold stable.
REQ-024 When out_valid=0, out_a SHALL be 00 and out_err SHALL be 0.
REQ-025 err_cnt SHALL increment by 1 on each accept whose word sets err, and SHALL saturate at 255 with no wrap.
REQ-026 FULL with in_valid=1 SHALL leave the offered word unaccepted and the stored data unchanged; upstream holds the word.
REQ-027 Write and read pointers SHALL wrap modulo 2.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously force:
- state EMPTY, both pointers 0
- out_valid=0, out_a=00, out_err=0
- err_cnt=0, in_ready=0
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries; no partial pop or accept SHALL complete on that edge.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 Reset, then the words 0001, 0010, 0100, 1000 with out_ready=1 -> out_a = 00, 01, 10, 11 with out_err=0, each one cycle after accept; err_cnt=0.
REQ-032 in_y=0000 then in_y=0110, with PRIORITY_HIGH=1 -> (00, err=1) then (10, err=1), err_cnt=2; with PRIORITY_HIGH=0, 0110 -> 01.
REQ-033 out_ready=0 and 3 words offered (0001, 0100, 1000) -> first two accepted, in_ready=0, third held; out_a stable at 00; release out_ready -> outputs 00, 10, 11 in order.
REQ-034 In ONE state, in_valid=1 and out_ready=1 for 4 consecutive cycles -> one result per cycle, state remains ONE, no word lost or duplicated.
REQ-035 260 accepted words of 0000 -> err_cnt stops at 255; then rst_n pulsed low mid-stream -> out_valid=0 and err_cnt=0 immediately, without waiting for a clock edge.
